// File: rtl/noc_traffic_injector.sv
// Synthetic wormhole packet source for the local input port of one mesh router.
// Issues fixed-length head/body/tail packets to pseudo-random XY destinations
// at a fixed tick period, handing flits over a valid/ready handshake.
module noc_traffic_injector #(
    parameter int          DATA_W     = 32,
    parameter int          MESH_X     = 5,
    parameter int          MESH_Y     = 5,
    parameter int          MY_X       = 0,
    parameter int          MY_Y       = 0,
    parameter int          PKT_LEN    = 4,
    parameter int          INJ_PERIOD = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          MAX_PKTS   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [DATA_W+1:0] flit_out,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic [15:0]       pkts_sent,
    output logic [15:0]       stall_cycles,
    output logic              done
);

    localparam int              CNT_W      = (INJ_PERIOD > 1) ? $clog2(INJ_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(INJ_PERIOD - 1);
    localparam logic [15:0]     LFSR_MASK  = 16'hB400;

    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_TAIL} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] tick_cnt_reg;
    logic [3:0]       owed_reg;
    logic [15:0]      lfsr_reg;
    logic [3:0]       dst_x_reg, dst_y_reg;
    logic [15:0]      seq_reg, idx_reg;
    logic [15:0]      pkts_sent_reg, stall_reg;
    logic             done_reg;

    logic             tick, accept, launch, last_body, done_hit, tail_accept;
    logic [15:0]      pkts_inc;
    logic [3:0]       dx_wrap, dy_wrap, dx_pick;
    logic [1:0]       flit_type;
    logic [DATA_W-1:0] payload;

    assign tick        = en && (tick_cnt_reg == '0);
    assign flit_valid  = (state_reg != S_IDLE);
    assign accept      = flit_valid && flit_ready;
    assign tail_accept = (state_reg == S_TAIL) && accept;
    assign last_body   = (idx_reg == 16'(PKT_LEN - 2));
    assign pkts_inc    = pkts_sent_reg + 16'd1;
    assign done_hit    = (MAX_PKTS != 0) && (pkts_inc == 16'(MAX_PKTS));
    assign pkts_sent    = pkts_sent_reg;
    assign stall_cycles = stall_reg;
    assign done         = done_reg;

    // Destination from the current LFSR value: fold into the mesh, then skip self.
    always_comb begin
        dx_wrap = {1'b0, lfsr_reg[2:0]};
        dy_wrap = {1'b0, lfsr_reg[6:4]};
        if (dx_wrap >= 4'(MESH_X)) dx_wrap = dx_wrap - 4'(MESH_X);
        if (dy_wrap >= 4'(MESH_Y)) dy_wrap = dy_wrap - 4'(MESH_Y);
        dx_pick = dx_wrap;
        if (dx_wrap == 4'(MY_X) && dy_wrap == 4'(MY_Y))
            dx_pick = (dx_wrap == 4'(MESH_X - 1)) ? 4'd0 : dx_wrap + 4'd1;
    end

    // Next-state logic; launch marks entry into HEAD (consumes one owed tick).
    always_comb begin
        state_next = state_reg;
        launch     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if ((owed_reg != 4'd0 || tick) && !done_reg) begin
                    state_next = S_HEAD;
                    launch     = 1'b1;
                end
            end
            S_HEAD: begin
                if (accept) state_next = (PKT_LEN > 2) ? S_BODY : S_TAIL;
            end
            S_BODY: begin
                if (accept && last_body) state_next = S_TAIL;
            end
            S_TAIL: begin
                if (accept) begin
                    if (owed_reg != 4'd0 && !done_hit) begin
                        state_next = S_HEAD;
                        launch     = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Flit assembly from registered packet fields, so it is stable while stalled.
    always_comb begin
        flit_type = 2'b00;
        payload   = '0;
        case (state_reg)
            S_HEAD: begin
                flit_type     = 2'b01;
                payload[31:0] = {seq_reg, 4'(MY_Y), 4'(MY_X), dst_y_reg, dst_x_reg};
            end
            S_BODY: begin
                flit_type     = 2'b10;
                payload[31:0] = {seq_reg, idx_reg};
            end
            S_TAIL: begin
                flit_type     = 2'b11;
                payload[31:0] = {seq_reg, idx_reg};
            end
            default: ;
        endcase
        flit_out = {flit_type, payload};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Injection tick counter and saturating owed-tick count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt_reg <= CNT_RELOAD;
            owed_reg     <= 4'd0;
        end else begin
            if (en) tick_cnt_reg <= (tick_cnt_reg == '0) ? CNT_RELOAD : tick_cnt_reg - 1'b1;
            if (tick && !launch) begin
                if (owed_reg != 4'hF) owed_reg <= owed_reg + 4'd1;
            end else if (launch && !tick) begin
                owed_reg <= owed_reg - 4'd1;
            end
        end
    end

    // Packet fields: latched at head entry, index advanced per accepted flit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_reg  <= LFSR_SEED;
            dst_x_reg <= 4'd0;
            dst_y_reg <= 4'd0;
            seq_reg   <= 16'd0;
            idx_reg   <= 16'd0;
        end else begin
            if (state_reg == S_HEAD && accept)
                lfsr_reg <= lfsr_reg[0] ? ((lfsr_reg >> 1) ^ LFSR_MASK) : (lfsr_reg >> 1);
            if (launch) begin
                dst_x_reg <= dx_pick;
                dst_y_reg <= dy_wrap;
                seq_reg   <= (state_reg == S_TAIL) ? pkts_inc : pkts_sent_reg;
                idx_reg   <= 16'd0;
            end else if (accept && state_reg != S_TAIL) begin
                idx_reg <= idx_reg + 16'd1;
            end
        end
    end

    // Statistics: packets completed, stalled cycles, completion flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pkts_sent_reg <= 16'd0;
            stall_reg     <= 16'd0;
            done_reg      <= 1'b0;
        end else begin
            if (tail_accept) begin
                pkts_sent_reg <= pkts_inc;
                if (done_hit) done_reg <= 1'b1;
            end
            if (flit_valid && !flit_ready && stall_reg != 16'hFFFF)
                stall_reg <= stall_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_noc_traffic_injector.sv
// Bench for noc_traffic_injector: four differently parameterised instances,
// each checked every cycle against a packet-level reference model.
module tb_noc_traffic_injector;

    localparam int NI = 4;
    localparam int P_LEN [NI] = '{4, 4, 2, 3};
    localparam int P_PER [NI] = '{16, 2, 1, 4};
    localparam int P_MYX [NI] = '{0, 3, 2, 1};
    localparam int P_MYY [NI] = '{0, 1, 2, 4};
    localparam int P_MAX [NI] = '{0, 0, 0, 3};
    localparam int MX = 5;
    localparam int MY = 5;

    logic        clk = 1'b0;
    logic        rst_n [NI];
    logic        en_s  [NI];
    logic        rdy   [NI];
    logic [33:0] fo    [NI];
    logic        fv    [NI];
    logic [15:0] ps    [NI];
    logic [15:0] sc    [NI];
    logic        dn    [NI];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    task automatic check(input int inst, input string what, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL inst%0d %s: got %0h expected %0h", inst, what, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Expected flit for flit number c of a packet with sequence number seq.
    function automatic logic [33:0] exp_flit(input int c, input int len, input int seq,
                                             input logic [15:0] lf, input int myx, input int myy);
        int dx, dy;
        logic [15:0] s16, c16;
        logic [3:0]  x4, y4, mx4, my4;
        s16 = 16'(seq);
        c16 = 16'(c);
        if (c == 0) begin
            dx = int'(lf[2:0]);
            dy = int'(lf[6:4]);
            if (dx >= MX) dx -= MX;
            if (dy >= MY) dy -= MY;
            if (dx == myx && dy == myy) dx = (dx == MX - 1) ? 0 : dx + 1;
            x4 = 4'(dx); y4 = 4'(dy); mx4 = 4'(myx); my4 = 4'(myy);
            return {2'b01, s16, my4, mx4, y4, x4};
        end
        return {(c == len - 1) ? 2'b11 : 2'b10, s16, c16};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_inst
            localparam int L   = P_LEN[gi];
            localparam int PER = P_PER[gi];
            localparam int MXP = P_MAX[gi];

            noc_traffic_injector #(
                .DATA_W(32), .MESH_X(MX), .MESH_Y(MY),
                .MY_X(P_MYX[gi]), .MY_Y(P_MYY[gi]),
                .PKT_LEN(L), .INJ_PERIOD(PER),
                .LFSR_SEED(16'hACE1), .MAX_PKTS(MXP)
            ) dut (
                .clk(clk), .reset(rst_n[gi]), .en(en_s[gi]),
                .flit_out(fo[gi]), .flit_valid(fv[gi]), .flit_ready(rdy[gi]),
                .pkts_sent(ps[gi]), .stall_cycles(sc[gi]), .done(dn[gi])
            );

            // Model state: enabled-cycle count, pending ticks, flit being offered
            // (-1 = none), completed packets, stalls, destination LFSR.
            int          en_cnt, pend, cur, tails, stalls;
            bit          dn_m, hold;
            bit          armed = 1'b0;
            logic [15:0] lf;
            logic [33:0] prev_fo;

            // Compare outputs mid-cycle, then advance the model across the next edge.
            always @(negedge clk) begin : cmp
                bit tk, launch, mv, acc, dn_nx;
                if (armed) begin
                    mv = (cur >= 0);
                    check(gi, "flit_valid", fv[gi], mv);
                    check(gi, "pkts_sent", ps[gi], 16'(tails));
                    check(gi, "stall_cycles", sc[gi], 16'(stalls));
                    check(gi, "done", dn[gi], dn_m);
                    if (mv) check(gi, "flit_out", fo[gi], exp_flit(cur, L, tails, lf, P_MYX[gi], P_MYY[gi]));
                    if (hold && fv[gi]) check(gi, "flit_stable", fo[gi], prev_fo);
                end
                hold    = armed && fv[gi] && !rdy[gi] && rst_n[gi];
                prev_fo = fo[gi];
                if (!rst_n[gi]) begin
                    armed = 1'b1;
                    en_cnt = 0; pend = 0; cur = -1; tails = 0; stalls = 0;
                    dn_m = 1'b0; lf = 16'hACE1;
                end else if (armed) begin
                    mv     = (cur >= 0);
                    acc    = mv && rdy[gi];
                    tk     = en_s[gi] && (en_cnt % PER == PER - 1);
                    launch = 1'b0;
                    dn_nx  = dn_m;
                    if (en_s[gi]) en_cnt++;
                    if (mv && !rdy[gi] && stalls < 65535) stalls++;
                    if (!mv) begin
                        if ((pend > 0 || tk) && !dn_m) begin
                            cur = 0;
                            launch = 1'b1;
                        end
                    end else if (acc) begin
                        if (cur == 0) begin
                            check(gi, "dst_x_range", fo[gi][3:0] < 4'(MX), 1'b1);
                            check(gi, "dst_y_range", fo[gi][7:4] < 4'(MY), 1'b1);
                            check(gi, "dst_not_self", (fo[gi][3:0] == 4'(P_MYX[gi])) && (fo[gi][7:4] == 4'(P_MYY[gi])), 1'b0);
                            lf = lfsr_step(lf);
                        end
                        if (cur == L - 1) begin
                            tails++;
                            if (MXP != 0 && tails == MXP) dn_nx = 1'b1;
                            if (pend > 0 && !dn_nx) begin
                                cur = 0;
                                launch = 1'b1;
                            end else begin
                                cur = -1;
                            end
                        end else begin
                            cur++;
                        end
                    end
                    if (tk && !launch) begin
                        if (pend < 15) pend++;
                    end else if (launch && !tk) begin
                        pend--;
                    end
                    dn_m = dn_nx;
                end
            end
        end
    endgenerate

    // One clock step; inputs change 1 time unit after the edge.
    task automatic tick1();
        @(posedge clk);
        #1;
        rdy[2] = ($urandom_range(0, 3) != 0);
        rdy[3] = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        logic [33:0] hv [2];
        int nh, b_idle, bp0, d, k;
        bit found;
        logic [33:0] head0_exp, head1_exp;
        head0_exp = {2'b01, 32'h0000_0011};
        head1_exp = {2'b01, 32'h0001_0020};
        for (int i = 0; i < NI; i++) begin
            rst_n[i] = 1'b0;
            en_s[i]  = 1'b1;
            rdy[i]   = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check(i, "reset_valid", fv[i], 1'b0);
            check(i, "reset_pkts", ps[i], 16'd0);
            check(i, "reset_done", dn[i], 1'b0);
            check(i, "reset_stall", sc[i], 16'd0);
        end
        for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;

        // Steady injection on instance 0, saturation on instance 1.
        nh = 0;
        b_idle = 0;
        for (int c = 0; c < 170; c++) begin
            tick1();
            if (fv[0] && fo[0][33:32] == 2'b01 && nh < 2) begin
                hv[nh] = fo[0];
                nh++;
            end
            if (c >= 90 && !fv[1]) b_idle++;
        end
        check(0, "pkts_after_10_ticks", ps[0], 16'd10);
        check(0, "no_stall_yet", sc[0], 16'd0);
        check(0, "heads_seen", nh, 2);
        check(0, "first_head", hv[0], head0_exp);
        check(0, "second_head", hv[1], head1_exp);
        check(1, "b2b_idle_cycles", b_idle, 0);

        en_s[1] = 1'b0;
        bp0 = int'(ps[1]);

        // Stall instance 0 for 5 cycles while a body flit is offered.
        found = 1'b0;
        for (k = 0; k < 40; k++) begin
            if (fv[0] && fo[0][33:32] == 2'b10) begin
                found = 1'b1;
                break;
            end
            tick1();
        end
        check(0, "body_flit_found", found, 1'b1);
        rdy[0] = 1'b0;
        repeat (5) tick1();
        rdy[0] = 1'b1;
        check(0, "stall_count", sc[0], 16'd5);

        // Instance 1 drains only its owed ticks after enable drops.
        repeat (100) tick1();
        d = int'(ps[1]) - bp0;
        check(1, "drain_pkts_in_range", (d >= 14 && d <= 16), 1'b1);
        check(1, "drained_valid", fv[1], 1'b0);

        // Instance 2 must complete 1000 packets.
        for (k = 0; k < 8000 && ps[2] < 16'd1000; k++) tick1();
        check(2, "thousand_pkts", ps[2] >= 16'd1000, 1'b1);

        // Instance 3 stops after 3 packets, then is reset mid-body and restarts.
        check(3, "max_done", dn[3], 1'b1);
        check(3, "max_pkts", ps[3], 16'd3);
        check(3, "max_no_valid", fv[3], 1'b0);
        rst_n[3] = 1'b0;
        tick1();
        rst_n[3] = 1'b1;
        found = 1'b0;
        for (k = 0; k < 60; k++) begin
            tick1();
            if (fv[3] && fo[3][33:32] == 2'b10) begin
                found = 1'b1;
                break;
            end
        end
        check(3, "restart_body_found", found, 1'b1);
        rst_n[3] = 1'b0;
        tick1();
        check(3, "midbody_reset_valid", fv[3], 1'b0);
        check(3, "midbody_reset_pkts", ps[3], 16'd0);
        check(3, "midbody_reset_done", dn[3], 1'b0);
        rst_n[3] = 1'b1;
        repeat (200) tick1();
        check(3, "restart_done", dn[3], 1'b1);
        check(3, "restart_pkts", ps[3], 16'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
